// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/interrupt arbiter, PC redirect/flush sequencer and machine timer
// Optional: define TRAP_EXT_SYNC_EN to pass irq_ext through a 2-flop synchronizer.
module trap_ctrl #(
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_exc_valid,
  input  logic [3:0]  ex_exc_cause,
  input  logic        ex_mret,
  input  logic        csr_mstatus_mie,
  input  logic [2:0]  csr_mie,
  input  logic [31:0] csr_trap_vector,
  input  logic [31:0] csr_mepc,
  input  logic        irq_ext,
  input  logic        irq_soft,
  input  logic        tmr_wen,
  input  logic [1:0]  tmr_addr,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] tmr_rdata,
  output logic        trap_csr_valid,
  output logic [31:0] trap_csr_pc,
  output logic [31:0] trap_csr_cause,
  output logic        trap_redirect_valid,
  output logic [31:0] trap_redirect_pc,
  output logic        trap_flush,
  output logic [2:0]  trap_irq_pending
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [15:0] presc;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        mtip;
  logic        meip;
  logic        tick;
  logic [2:0]  irq_en;
  logic        take;
  logic [31:0] target;

`ifdef TRAP_EXT_SYNC_EN
  logic [1:0] ext_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_sync <= 2'b00;
    end else begin
      ext_sync <= {ext_sync[0], irq_ext};
    end
  end

  assign meip = ext_sync[1];
`else
  assign meip = irq_ext;
`endif

  assign tick = (presc == 16'(TICK_DIV - 1));

  // mtip is registered so a mtimecmp write shows up on the pending bit two cycles later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= 16'd0;
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip     <= 1'b0;
    end else begin
      mtip <= (mtime >= mtimecmp);
      if (tmr_wen && tmr_addr[1]) begin
        presc <= 16'd0;
        if (tmr_addr[0]) mtime[63:32] <= tmr_wdata;
        else             mtime[31:0]  <= tmr_wdata;
      end else begin
        presc <= tick ? 16'd0 : presc + 16'd1;
        if (tick) mtime <= mtime + 64'd1;
      end
      if (tmr_wen && !tmr_addr[1]) begin
        if (tmr_addr[0]) mtimecmp[63:32] <= tmr_wdata;
        else             mtimecmp[31:0]  <= tmr_wdata;
      end
    end
  end

  always_comb begin
    case (tmr_addr)
      2'd0:    tmr_rdata = mtimecmp[31:0];
      2'd1:    tmr_rdata = mtimecmp[63:32];
      2'd2:    tmr_rdata = mtime[31:0];
      default: tmr_rdata = mtime[63:32];
    endcase
  end

  assign trap_irq_pending = {meip, mtip, irq_soft};
  assign irq_en           = trap_irq_pending & csr_mie & {3{csr_mstatus_mie}};

  always_comb begin
    trap_csr_valid = 1'b0;
    trap_csr_cause = 32'd0;
    take           = 1'b0;
    target         = 32'd0;
    if (state == S_IDLE && ex_valid) begin
      if (ex_exc_valid) begin
        trap_csr_valid = 1'b1;
        trap_csr_cause = {28'd0, ex_exc_cause};
      end else if (irq_en[2]) begin
        trap_csr_valid = 1'b1;
        trap_csr_cause = 32'h8000_000B;
      end else if (irq_en[0]) begin
        trap_csr_valid = 1'b1;
        trap_csr_cause = 32'h8000_0003;
      end else if (irq_en[1]) begin
        trap_csr_valid = 1'b1;
        trap_csr_cause = 32'h8000_0007;
      end
      if (trap_csr_valid) begin
        take   = 1'b1;
        target = csr_trap_vector;
      end else if (ex_mret) begin
        take   = 1'b1;
        target = csr_mepc;
      end
    end
  end

  // An interrupt taken on an mret captures the mret's own PC so it re-executes on return
  assign trap_csr_pc = trap_csr_valid ? ex_pc : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      flush_cnt           <= 4'd0;
      trap_redirect_valid <= 1'b0;
      trap_redirect_pc    <= 32'd0;
      trap_flush          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          trap_redirect_valid <= 1'b0;
          if (take) begin
            state               <= S_FLUSH;
            trap_redirect_valid <= 1'b1;
            trap_redirect_pc    <= target;
            trap_flush          <= 1'b1;
            flush_cnt           <= 4'(FLUSH_CYCLES - 1);
          end
        end
        default: begin
          trap_redirect_valid <= 1'b0;
          if (flush_cnt == 4'd0) begin
            trap_flush <= 1'b0;
            state      <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed plus randomized bench for trap_ctrl against a cycle-level reference model
module tb_trap_ctrl;

  localparam int TD = 3;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid, ex_exc_valid, ex_mret, csr_mstatus_mie;
  logic [31:0] ex_pc, csr_trap_vector, csr_mepc, tmr_wdata;
  logic [3:0]  ex_exc_cause;
  logic [2:0]  csr_mie;
  logic        irq_ext, irq_soft, tmr_wen;
  logic [1:0]  tmr_addr;
  logic [31:0] tmr_rdata, trap_csr_pc, trap_csr_cause, trap_redirect_pc;
  logic        trap_csr_valid, trap_redirect_valid, trap_flush;
  logic [2:0]  trap_irq_pending;

  trap_ctrl #(.TICK_DIV(TD), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_exc_valid(ex_exc_valid),
    .ex_exc_cause(ex_exc_cause), .ex_mret(ex_mret),
    .csr_mstatus_mie(csr_mstatus_mie), .csr_mie(csr_mie),
    .csr_trap_vector(csr_trap_vector), .csr_mepc(csr_mepc),
    .irq_ext(irq_ext), .irq_soft(irq_soft),
    .tmr_wen(tmr_wen), .tmr_addr(tmr_addr), .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata),
    .trap_csr_valid(trap_csr_valid), .trap_csr_pc(trap_csr_pc), .trap_csr_cause(trap_csr_cause),
    .trap_redirect_valid(trap_redirect_valid), .trap_redirect_pc(trap_redirect_pc),
    .trap_flush(trap_flush), .trap_irq_pending(trap_irq_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: timer as plain 64-bit arithmetic, flush as a countdown of remaining cycles
  logic [63:0] m_time, m_cmp;
  int          m_presc, m_flush;
  bit          m_tip, m_redir;
  logic [31:0] m_rpc;
`ifdef TRAP_EXT_SYNC_EN
  logic [1:0]  m_ext_hist;
`endif

  task automatic model_reset();
    m_time = 64'd0; m_cmp = '1; m_presc = 0; m_flush = 0;
    m_tip = 0; m_redir = 0; m_rpc = 32'd0;
`ifdef TRAP_EXT_SYNC_EN
    m_ext_hist = 2'b00;
`endif
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_pc = 0; ex_exc_valid = 0; ex_exc_cause = 0; ex_mret = 0;
    csr_mstatus_mie = 0; csr_mie = 0; csr_trap_vector = 0; csr_mepc = 0;
    irq_ext = 0; irq_soft = 0; tmr_wen = 0; tmr_addr = 0; tmr_wdata = 0;
  endtask

  // Called just after a negedge with inputs set; checks this cycle, then advances one clock
  task automatic step();
    logic [2:0]  pend, en;
    logic [31:0] cause, tgt, rd;
    bit          v, take, new_tip;
    #1;
`ifdef TRAP_EXT_SYNC_EN
    pend[2] = m_ext_hist[1];
`else
    pend[2] = irq_ext;
`endif
    pend[1] = m_tip;
    pend[0] = irq_soft;
    en = pend & csr_mie & {3{csr_mstatus_mie}};
    v = 0; take = 0; cause = 0; tgt = 0;
    if (m_flush == 0 && ex_valid) begin
      if (ex_exc_valid) begin v = 1; cause = {28'd0, ex_exc_cause}; end
      else if (en[2]) begin v = 1; cause = 32'h8000000B; end
      else if (en[0]) begin v = 1; cause = 32'h80000003; end
      else if (en[1]) begin v = 1; cause = 32'h80000007; end
      if (v) begin take = 1; tgt = csr_trap_vector; end
      else if (ex_mret) begin take = 1; tgt = csr_mepc; end
    end
    rd = (tmr_addr == 0) ? m_cmp[31:0] : (tmr_addr == 1) ? m_cmp[63:32] :
         (tmr_addr == 2) ? m_time[31:0] : m_time[63:32];
    check("csr_valid", trap_csr_valid, v);
    check("csr_pc", trap_csr_pc, v ? ex_pc : 32'd0);
    check("csr_cause", trap_csr_cause, cause);
    check("pending", trap_irq_pending, pend);
    check("rdata", tmr_rdata, rd);
    check("redir_valid", trap_redirect_valid, m_redir);
    check("redir_pc", trap_redirect_pc, m_rpc);
    check("flush", trap_flush, m_flush > 0);
    @(posedge clk);
    new_tip = (m_time >= m_cmp);
    if (tmr_wen && tmr_addr >= 2) begin
      m_presc = 0;
      if (tmr_addr == 3) m_time[63:32] = tmr_wdata; else m_time[31:0] = tmr_wdata;
    end else if (m_presc == TD - 1) begin
      m_presc = 0;
      m_time = m_time + 64'd1;
    end else begin
      m_presc++;
    end
    if (tmr_wen && tmr_addr == 0) m_cmp[31:0] = tmr_wdata;
    if (tmr_wen && tmr_addr == 1) m_cmp[63:32] = tmr_wdata;
    m_tip = new_tip;
`ifdef TRAP_EXT_SYNC_EN
    m_ext_hist = {m_ext_hist[0], irq_ext};
`endif
    if (take) begin
      m_flush = FC; m_redir = 1; m_rpc = tgt;
    end else begin
      m_redir = 0;
      if (m_flush > 0) m_flush--;
    end
    @(negedge clk);
  endtask

  task automatic tmr_write(input logic [1:0] a, input logic [31:0] d);
    tmr_wen = 1; tmr_addr = a; tmr_wdata = d;
    step();
    tmr_wen = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #2 rst = 0;
    #1;
    tmr_addr = 1;
    #1;
    check("rst_rdata_cmp_hi", tmr_rdata, 32'hFFFFFFFF);
    check("rst_flush", trap_flush, 0);
    check("rst_redir", trap_redirect_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    tmr_addr = 0;

    // Synchronous exception
    ex_valid = 1; ex_exc_valid = 1; ex_exc_cause = 11; ex_pc = 32'h80000010;
    csr_trap_vector = 32'h80000100;
    #1;
    check("exc_valid", trap_csr_valid, 1);
    check("exc_pc", trap_csr_pc, 32'h80000010);
    check("exc_cause", trap_csr_cause, 32'h0000000B);
    step();
    ex_valid = 0; ex_exc_valid = 0;
    check("exc_redir", trap_redirect_valid, 1);
    check("exc_redir_pc", trap_redirect_pc, 32'h80000100);
    check("exc_flush1", trap_flush, 1);
    step();
    check("exc_flush2", trap_flush, 1);
    check("exc_redir_once", trap_redirect_valid, 0);
    step();
    check("exc_flush_end", trap_flush, 0);

    // mret with exceptions offered during the flush
    ex_valid = 1; ex_mret = 1; csr_mepc = 32'h80000044;
    #1;
    check("mret_no_csr", trap_csr_valid, 0);
    step();
    ex_mret = 0; ex_exc_valid = 1; ex_exc_cause = 5;
    check("mret_redir_pc", trap_redirect_pc, 32'h80000044);
    step();
    step();
    ex_exc_valid = 0; ex_valid = 0;
    step();

    // Gating by mstatus.mie
    irq_ext = 1; csr_mie = 3'b100; csr_mstatus_mie = 0; ex_valid = 1;
    #1;
    check("gate_pending", trap_irq_pending, 3'b100);
    check("gate_no_trap", trap_csr_valid, 0);
    step();
    csr_mstatus_mie = 1;
    #1;
    check("gate_ext_cause", trap_csr_cause, 32'h8000000B);
    step();
    irq_ext = 0; ex_valid = 0;
    repeat (3) step();

    // Timer interrupt
    tmr_write(1, 32'd0);
    tmr_write(0, 32'd5);
    csr_mie = 3'b010;
    for (int i = 0; i < 200 && !trap_irq_pending[1]; i++) step();
    check("tmr_mtip_rise", trap_irq_pending[1], 1);
    ex_valid = 1; ex_pc = 32'h80000200;
    #1;
    check("tmr_cause", trap_csr_cause, 32'h80000007);
    step();
    ex_valid = 0;
    repeat (3) step();

    // Priority: exception over all three interrupts, then external over the rest
    irq_ext = 1; irq_soft = 1; csr_mie = 3'b111; ex_valid = 1; ex_exc_valid = 1; ex_exc_cause = 2;
    #1;
    check("prio_exc", trap_csr_cause, 32'h00000002);
    step();
    step();
    step();
    ex_exc_valid = 0;
    #1;
    check("prio_ext", trap_csr_cause, 32'h8000000B);
    step();
    irq_ext = 0; irq_soft = 0; ex_valid = 0;
    repeat (3) step();
    tmr_write(1, 32'hFFFFFFFF);
    tmr_write(0, 32'hFFFFFFFF);
    step();
    #1;
    check("tmr_mtip_drop", trap_irq_pending[1], 0);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ex_valid        = 1'($urandom_range(0, 1));
      ex_pc           = $urandom;
      ex_exc_valid    = ($urandom_range(0, 5) == 0);
      ex_exc_cause    = 4'($urandom);
      ex_mret         = ($urandom_range(0, 5) == 0);
      csr_mstatus_mie = ($urandom_range(0, 3) != 0);
      csr_mie         = 3'($urandom);
      csr_trap_vector = $urandom;
      csr_mepc        = $urandom;
      irq_ext         = ($urandom_range(0, 7) == 0);
      irq_soft        = ($urandom_range(0, 7) == 0);
      tmr_addr        = 2'($urandom);
      tmr_wen         = ($urandom_range(0, 9) == 0);
      case (tmr_addr)
        2'd0:    tmr_wdata = m_time[31:0] + $urandom_range(0, 30);
        2'd1:    tmr_wdata = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : m_time[63:32];
        2'd2:    tmr_wdata = $urandom_range(0, 1) ? $urandom : 32'hFFFFFFF0;
        default: tmr_wdata = $urandom_range(0, 1) ? 32'd0 : 32'hFFFFFFFF;
      endcase
      step();
    end
    idle_inputs();
    step();

    // Asynchronous reset in the middle of a flush
    ex_valid = 1; ex_exc_valid = 1; ex_exc_cause = 3; csr_trap_vector = 32'h1234;
    step();
    idle_inputs();
    tmr_addr = 1;
    check("mid_flush_active", trap_flush, 1);
    rst = 0;
    #1;
    check("arst_flush", trap_flush, 0);
    check("arst_redir", trap_redirect_valid, 0);
    check("arst_redir_pc", trap_redirect_pc, 0);
    check("arst_rdata", tmr_rdata, 32'hFFFFFFFF);
    model_reset();
    @(negedge clk);
    rst = 1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/interrupt controller directly upstream of the CSR file.
- Arbitrates synchronous exceptions from EX, mret, and machine interrupts (external, software, timer).
- Drives the CSR trap-capture interface and issues a PC redirect plus a pipeline flush to fetch/decode.
- Contains the machine timer (mtime/mtimecmp) and its prescaler.

Parameters:
TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.
FLUSH_CYCLES, 2, cycles trap_flush stays high after a redirect; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
ex_valid  in  1  valid instruction in EX this cycle
ex_pc  in  32  PC of the EX instruction
ex_exc_valid  in  1  EX instruction raised a synchronous exception
ex_exc_cause  in  4  exception code (0..15)
ex_mret  in  1  EX instruction is mret
csr_mstatus_mie  in  1  global interrupt enable from CSR
csr_mie  in  3  {meie, mtie, msie} from CSR
csr_trap_vector  in  32  mtvec base from CSR
csr_mepc  in  32  mepc from CSR
irq_ext  in  1  external interrupt, level, asynchronous source
irq_soft  in  1  software interrupt, level, synchronous
tmr_wen  in  1  timer register write strobe
tmr_addr  in  2  0=mtimecmp[31:0], 1=mtimecmp[63:32], 2=mtime[31:0], 3=mtime[63:32]
tmr_wdata  in  32  timer write data
tmr_rdata  out  32  timer read data, combinational on tmr_addr
trap_csr_valid  out  1  trap capture strobe to CSR
trap_csr_pc  out  32  PC to write into mepc
trap_csr_cause  out  32  value to write into mcause
trap_redirect_valid  out  1  one-cycle PC redirect to fetch
trap_redirect_pc  out  32  redirect target
trap_flush  out  1  kill IF/ID/EX contents
trap_irq_pending  out  3  {meip, mtip, msip}, raw pending status

Behaviour:
- Reset (rst=0, async):
  - State IDLE; flush counter 0; prescaler 0.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - Synchronizer flops cleared.
  - All registered outputs 0; trap_redirect_pc=0.
  - Reset asserted mid-FLUSH aborts the flush immediately.
- Pending bits:
  - meip = synchronized irq_ext.
  - mtip = (mtime >= mtimecmp), 64-bit unsigned compare.
  - msip = irq_soft.
  - All are levels; nothing is latched. Clearing is the source's responsibility (for mtip, writing mtimecmp).
- Enabled interrupt: csr_mstatus_mie & pending & csr_mie, evaluated per bit.
- States:
  - IDLE: in cycle T with ex_valid=1, priority is exception > interrupt > mret.
    - Exception: trap_csr_valid=1 combinationally in T; trap_csr_pc=ex_pc; trap_csr_cause={28'b0, ex_exc_cause}.
    - Interrupt: priority external(11) > software(3) > timer(7); cause={1'b1, 27'b0, code}; trap_csr_pc=ex_pc. The EX instruction is not retired.
    - Trap taken: register target=csr_trap_vector; go to FLUSH.
    - mret without exception/interrupt: no CSR strobe; target=csr_mepc; go to FLUSH.
    - Interrupt plus mret in the same cycle: the interrupt is taken and mepc=ex_pc, so mret re-executes later.
    - ex_valid=0: no action; interrupts stay pending.
  - FLUSH: in T+1, trap_redirect_valid=1 for exactly one cycle with the registered target.
    - trap_flush=1 from T+1 through T+FLUSH_CYCLES, then return to IDLE.
    - All EX inputs are ignored and trap_csr_valid is held 0.
- Outputs when idle: trap_csr_pc and trap_csr_cause are 0 whenever trap_csr_valid=0.
- Timer:
  - The prescaler counts 0..TICK_DIV-1; mtime increments by 1 on wrap. 64-bit wrap from all-ones to 0 is allowed.
  - A tmr_wen to a mtime half replaces that half. The other half and any increment are suppressed that cycle, and the prescaler resets to 0.
  - mtimecmp writes take effect the next cycle; mtip updates the cycle after that.

Optional Feature:
TRAP_EXT_SYNC_EN
- Defined: irq_ext passes through a 2-flop synchronizer; meip lags irq_ext by 2 cycles.
- Undefined: meip = irq_ext directly, same cycle. Use only when the source is synchronous to clk.

Test Plan:
- Exception: ex_valid=1, ex_exc_valid=1, cause=11, ex_pc=0x80000010, mtvec=0x80000100 -> in T, trap_csr_valid=1, pc=0x80000010, cause=0x0000000B; in T+1, redirect to 0x80000100; flush high T+1..T+2.
- Timer interrupt: TICK_DIV=1, mtimecmp=5, mie=3'b010, mstatus_mie=1, ex_valid=1 -> mtip rises once mtime reaches 5; cause=0x80000007 in the first valid cycle after; writing mtimecmp=all-ones drops mtip.
- Priority: ext, soft, and timer interrupts all pending and enabled, plus ex_exc_valid with cause=2 -> cause=0x00000002; next IDLE cycle -> 0x8000000B.
- mret: ex_mret=1, csr_mepc=0x80000044 -> no trap_csr_valid; redirect to 0x80000044 in T+1; flush 2 cycles; new exceptions during FLUSH ignored.
- Gating: meip pending, mstatus_mie=0 -> no trap; trap_irq_pending=3'b100; set mstatus_mie=1 -> trap in the next ex_valid cycle.
- Async reset asserted mid-FLUSH -> flush/redirect outputs 0 immediately, tmr_rdata (addr 1) = 0xFFFFFFFF.
